uart_rx_fifo: RTL and testbench

//   UART receiver: the receive-side counterpart of the micro controller's UART Tx path.

---
 rtl/uart_rx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling 8N1 UART receiver feeding a small
// first-word-fall-through FIFO, with single-cycle framing/overrun pulses.
module uart_rx_fifo #(
    parameter int unsigned CLK_DIVIDE = 54,
    parameter int unsigned NBITS      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_UART_Rx,
    output logic [NBITS-1:0] o_data,
    output logic             o_data_valid,
    input  logic             i_data_rd,
    output logic             o_frame_err,
    output logic             o_overrun,
    output logic             o_busy
);

    localparam int unsigned DIV_W = (CLK_DIVIDE > 1) ? $clog2(CLK_DIVIDE) : 1;
    localparam int unsigned BIT_W = $clog2(NBITS + 1);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_s_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         sub_q, sub_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [NBITS-1:0]   shreg_q, shreg_d;
    logic               tick, sample, wrap;
    logic               align_clr, bit_clr, shift_en, push_req, ferr_d;
    logic [NBITS-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic               empty, full, pop, push, ovr_d;
    logic               frame_err_q, overrun_q;

    // Two-flop synchronizer; idles high so reset looks like a quiet line
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_UART_Rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign tick   = (div_q == DIV_W'(CLK_DIVIDE - 1));
    assign sample = tick && (sub_q == 4'd7);
    assign wrap   = tick && (sub_q == 4'd15);

    // Receiver state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_WAIT_IDLE;
        else       state_q <= state_d;
    end

    // Receiver next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT_IDLE: if (rx_s_q) state_d = S_IDLE;
            S_IDLE:      if (!rx_s_q) state_d = S_START;
            S_START: begin
                if (sample && rx_s_q) state_d = S_IDLE;
                else if (wrap)        state_d = S_DATA;
            end
            S_DATA:      if (wrap && (bit_q == BIT_W'(NBITS))) state_d = S_STOP;
            S_STOP:      if (sample) state_d = rx_s_q ? S_IDLE : S_WAIT_IDLE;
            default:     state_d = S_WAIT_IDLE;
        endcase
    end

    // Receiver control outputs decoded from the current state
    always_comb begin
        align_clr = (state_q == S_IDLE) && !rx_s_q;
        bit_clr   = (state_q == S_START) && wrap;
        shift_en  = (state_q == S_DATA) && sample;
        push_req  = (state_q == S_STOP) && sample && rx_s_q;
        ferr_d    = (state_q == S_STOP) && sample && !rx_s_q;
        o_busy    = (state_q != S_IDLE) && !i_rst;
    end

    // Oversampling divider, subcount, bit index and shift register next values
    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        sub_d   = tick ? sub_q + 4'd1 : sub_q;
        if (align_clr) begin
            div_d = '0;
            sub_d = '0;
        end
        bit_d   = bit_q;
        if (bit_clr)       bit_d = '0;
        else if (shift_en) bit_d = bit_q + 1'b1;
        shreg_d = shift_en ? {rx_s_q, shreg_q[NBITS-1:1]} : shreg_q;
    end

    // Receiver datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q   <= '0;
            sub_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            div_q   <= div_d;
            sub_q   <= sub_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    // Pointers carry an extra wrap bit so full and empty are distinguishable;
    // a push at full is still accepted when the head is popped in the same cycle.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = i_data_rd && !empty;
    assign push  = push_req && (!full || pop);
    assign ovr_d = push_req && full && !pop;
    assign wr_d  = push ? wr_q + 1'b1 : wr_q;
    assign rd_d  = pop  ? rd_q + 1'b1 : rd_q;

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= shreg_q;
    end

    // FIFO pointers and registered event pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_q        <= '0;
            rd_q        <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            frame_err_q <= ferr_d;
            overrun_q   <= ovr_d;
        end
    end

    assign o_data       = empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign o_data_valid = !empty;
    assign o_frame_err  = frame_err_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed, table-driven and randomized checks of uart_rx_fifo.
module tb_uart_rx_fifo;

    localparam int BIT_P = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rd  = 1'b0;
    logic [7:0] o_data;
    logic       o_valid, o_ferr, o_ovr, o_busy;

    int checks = 0;
    int failures = 0;
    int ferr_cnt = 0, ovr_cnt = 0, wide_cnt = 0, busy_drop = 0;
    logic ferr_prev = 1'b0, ovr_prev = 1'b0;
    logic busy_watch = 1'b0;
    int lat = 0;

    uart_rx_fifo #(.CLK_DIVIDE(4), .NBITS(8), .FIFO_DEPTH(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_UART_Rx    (rx),
        .o_data       (o_data),
        .o_data_valid (o_valid),
        .i_data_rd    (rd),
        .o_frame_err  (o_ferr),
        .o_overrun    (o_ovr),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    // Count event pulses and flag any pulse wider than one cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (o_ferr) ferr_cnt <= ferr_cnt + 1;
            if (o_ovr)  ovr_cnt  <= ovr_cnt + 1;
            if ((o_ferr && ferr_prev) || (o_ovr && ovr_prev)) wide_cnt <= wide_cnt + 1;
            if (busy_watch && !o_busy) busy_drop <= busy_drop + 1;
        end
        ferr_prev <= o_ferr;
        ovr_prev  <= o_ovr;
    end

    initial begin
        #800000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h req=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v, input int p);
        rx = v;
        cyc(p);
    endtask

    task automatic send_head(input logic [7:0] d, input int p);
        send_bit(1'b0, p);
        for (int i = 0; i < 8; i++) send_bit(d[i], p);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int p);
        send_head(d, p);
        send_bit(stop, p);
        rx = 1'b1;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        @(negedge clk);
        chk({name, "_valid"}, 32'(o_valid), 32'd1);
        chk({name, "_data"}, 32'(o_data), 32'(exp));
        rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         p;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];
    logic [7:0] model_q[$];
    logic [7:0] byte6[3];
    int periods[2];

    initial begin
        int f0, o0, got, npop;
        logic [7:0] d, e;
        logic ok;
        int p;

        vecs[0] = '{8'h12, 1'b1, 64, 1'b1, 8'h12, 0};
        vecs[1] = '{8'hFE, 1'b0, 64, 1'b0, 8'h00, 1};
        vecs[2] = '{8'h80, 1'b1, 63, 1'b1, 8'h80, 0};
        vecs[3] = '{8'h7F, 1'b1, 65, 1'b1, 8'h7F, 0};
        vecs[4] = '{8'h00, 1'b0, 64, 1'b0, 8'h00, 1};
        vecs[5] = '{8'hC3, 1'b1, 62, 1'b1, 8'hC3, 0};

        // Reset state
        cyc(3);
        chk("reset_outputs", 32'({o_data, o_valid, o_ferr, o_ovr, o_busy}), 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 chk("busy_after_reset", 32'(o_busy), 32'd1);
        cyc(4);
        chk("busy_idle", 32'(o_busy), 32'd0);

        // 1: 0xA5 with latency to valid
        f0 = ferr_cnt; o0 = ovr_cnt;
        send_head(8'hA5, BIT_P);
        rx = 1'b1;
        got = 0;
        for (int n = 1; n <= 60 && got == 0; n++) begin
            @(negedge clk);
            if (o_valid) begin
                got = 1;
                lat = n - 1;
            end
        end
        chk("t1_valid_seen", 32'(got), 32'd1);
        chk("t1_latency_ok", 32'(lat >= 33 && lat <= 37), 32'd1);
        cyc(BIT_P);
        chk("t1_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("t1_no_ovr", 32'(ovr_cnt - o0), 32'd0);
        pop_check("t1", 8'hA5);
        @(negedge clk) chk("t1_empty", 32'(o_valid), 32'd0);
        cyc(1);

        // 2: short low glitch is rejected as a false start
        f0 = ferr_cnt;
        rx = 1'b0;
        cyc(20);
        rx = 1'b1;
        cyc(5);
        chk("t2_busy_in_start", 32'(o_busy), 32'd1);
        cyc(20);
        chk("t2_busy_dropped", 32'(o_busy), 32'd0);
        chk("t2_no_push", 32'(o_valid), 32'd0);
        chk("t2_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // 3: bad stop then break; busy held until line returns high
        f0 = ferr_cnt;
        send_head(8'h3C, BIT_P);
        busy_watch = 1'b1;
        send_bit(1'b0, BIT_P);
        cyc(10 * BIT_P);
        busy_watch = 1'b0;
        chk("t3_busy_held", 32'(busy_drop), 32'd0);
        chk("t3_one_ferr", 32'(ferr_cnt - f0), 32'd1);
        chk("t3_no_push", 32'(o_valid), 32'd0);
        rx = 1'b1;
        cyc(BIT_P);
        send_frame(8'h55, 1'b1, BIT_P);
        cyc(4);
        pop_check("t3", 8'h55);

        // 4: overrun at full, then pop coinciding with push at full
        f0 = ferr_cnt; o0 = ovr_cnt;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, BIT_P);
        cyc(4);
        chk("t4_one_ovr", 32'(ovr_cnt - o0), 32'd1);
        for (int k = 1; k <= 4; k++) pop_check("t4_order", 8'(k));
        @(negedge clk) chk("t4_drained", 32'(o_valid), 32'd0);
        cyc(1);
        o0 = ovr_cnt;
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, BIT_P);
        send_head(8'h05, BIT_P);
        rx = 1'b1;
        cyc(lat - 1);
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
        cyc(BIT_P);
        chk("t4_no_ovr_with_pop", 32'(ovr_cnt - o0), 32'd0);
        for (int k = 2; k <= 5; k++) pop_check("t4_popush", 8'(k));
        @(negedge clk) chk("t4_drained2", 32'(o_valid), 32'd0);
        chk("t4_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        cyc(1);

        // 5: reset mid-frame clears FIFO and drops the partial character
        send_frame(8'h33, 1'b1, BIT_P);
        send_bit(1'b0, BIT_P);
        for (int i = 0; i < 3; i++) send_bit(1'b1, BIT_P);
        cyc(30);
        #2 rst = 1'b1;
        #1 chk("t5_outputs_in_reset", 32'({o_data, o_valid, o_ferr, o_ovr, o_busy}), 32'd0);
        cyc(3);
        @(negedge clk) rst = 1'b0;
        #1 chk("t5_busy_after_release", 32'(o_busy), 32'd1);
        cyc(8 * BIT_P);
        chk("t5_no_partial", 32'(o_valid), 32'd0);
        send_frame(8'h81, 1'b1, BIT_P);
        cyc(4);
        pop_check("t5", 8'h81);
        @(negedge clk) chk("t5_empty", 32'(o_valid), 32'd0);
        cyc(1);

        // 6: +/-3% bit period tolerance
        byte6[0] = 8'h00; byte6[1] = 8'hFF; byte6[2] = 8'h5A;
        periods[0] = 62; periods[1] = 66;
        for (int j = 0; j < 2; j++) begin
            f0 = ferr_cnt;
            for (int i = 0; i < 3; i++) send_frame(byte6[i], 1'b1, periods[j]);
            cyc(4);
            for (int i = 0; i < 3; i++) pop_check("t6", byte6[i]);
            chk("t6_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        end

        // Table-driven vectors
        foreach (vecs[i]) begin
            f0 = ferr_cnt;
            send_frame(vecs[i].d, vecs[i].stop, vecs[i].p);
            cyc(16);
            @(negedge clk);
            chk("vec_valid", 32'(o_valid), 32'(vecs[i].exp_valid));
            chk("vec_ferr", 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            cyc(1);
            if (vecs[i].exp_valid) pop_check("vec", vecs[i].exp_data);
        end

        // Randomized frames against a queue model of capacity 4
        model_q.delete();
        for (int it = 0; it < 40; it++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            p  = $urandom_range(62, 66);
            f0 = ferr_cnt; o0 = ovr_cnt;
            send_frame(d, ok, p);
            cyc($urandom_range(4, 30));
            chk("rnd_ferr", 32'(ferr_cnt - f0), 32'(!ok));
            chk("rnd_ovr", 32'(ovr_cnt - o0), 32'(ok && model_q.size() == 4));
            if (ok && model_q.size() < 4) model_q.push_back(d);
            @(negedge clk);
            chk("rnd_valid", 32'(o_valid), 32'(model_q.size() != 0));
            cyc(1);
            npop = $urandom_range(0, 2);
            if (npop > model_q.size()) npop = model_q.size();
            for (int k = 0; k < npop; k++) begin
                e = model_q.pop_front();
                pop_check("rnd", e);
            end
        end
        while (model_q.size() != 0) begin
            e = model_q.pop_front();
            pop_check("rnd_drain", e);
        end
        @(negedge clk) chk("rnd_empty", 32'(o_valid), 32'd0);

        chk("pulse_width", 32'(wide_cnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
